// File: rtl/rv32i_arb_pkg.sv
// rv32i_arb_pkg: shared owner/tag types and defaults for the unified memory arbiter
package rv32i_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;
  function automatic rd_tag_t flush_tag(rd_tag_t t, logic flush_if, logic flush_d);
    rd_tag_t r;
    r = t;
    r.valid = t.valid & ~((t.owner == OWN_IF) ? flush_if : flush_d);
    return r;
  endfunction
endpackage

// File: rtl/rv32i_rd_lat_pipe.sv
// rv32i_rd_lat_pipe: DEPTH-deep {valid, owner} shift pipe tracking in-flight reads with per-owner flush
module rv32i_rd_lat_pipe
  import rv32i_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push_i,
  input  logic    flush_if_i,
  input  logic    flush_d_i,
  output rd_tag_t head_o
);
  rd_tag_t stage_q [DEPTH];
  // shift tags toward the head, dropping any whose owner is being flushed this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= flush_tag(push_i, flush_if_i, flush_d_i);
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= flush_tag(stage_q[i-1], flush_if_i, flush_d_i);
    end
  end
  assign head_o = flush_tag(stage_q[DEPTH-1], flush_if_i, flush_d_i);
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: single-port memory arbiter between fetch and load/store; RV32I_ARB_PERF_EN adds perf counters
module rv32i_mem_arbiter
  import rv32i_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RV32I_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_gnt
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              force_if;
  rd_tag_t           push, head;
  // data-first arbitration with starvation override; grants held low while in reset
  always_comb begin
    force_if     = starve_cnt_q == SW'(STARVE_MAX);
    if_gnt       = rst_n & if_req & (~d_req | force_if);
    d_gnt        = rst_n & d_req & ~if_gnt;
    mem_en       = if_gnt | d_gnt;
    mem_we       = d_gnt & d_we;
    mem_addr     = if_gnt ? if_addr : d_gnt ? d_addr : '0;
    mem_wdata    = d_gnt ? d_wdata : '0;
    starve_cnt_d = (if_req & ~if_gnt) ? (force_if ? starve_cnt_q : starve_cnt_q + SW'(1)) : '0;
    push         = '{valid: mem_en & ~mem_we, owner: d_gnt ? OWN_D : OWN_IF};
    if_rvalid    = head.valid & (head.owner == OWN_IF);
    d_rvalid     = head.valid & (head.owner == OWN_D);
    if_rdata     = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata      = d_rvalid ? mem_rdata : d_rdata_q;
  end
  rv32i_rd_lat_pipe #(.DEPTH(MEM_LAT)) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .flush_if_i(if_flush),
    .flush_d_i (1'b0),
    .head_o    (head)
  );
  // starvation counter and per-requester read-data hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if_rdata_q   <= if_rdata;
      d_rdata_q    <= d_rdata;
    end
  end
`ifdef RV32I_ARB_PERF_EN
  logic [31:0] perf_if_stall_q, perf_d_gnt_q;
  // saturating counters for fetch stall cycles and data grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_stall_q <= '0;
      perf_d_gnt_q    <= '0;
    end else begin
      perf_if_stall_q <= perf_if_stall_q + 32'(if_req && !if_gnt && perf_if_stall_q != '1);
      perf_d_gnt_q    <= perf_d_gnt_q + 32'(d_gnt && perf_d_gnt_q != '1);
    end
  end
  assign perf_if_stall = perf_if_stall_q;
  assign perf_d_gnt    = perf_d_gnt_q;
`endif
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed checks of arbitration, latency, flush and reset behaviour
module tb_rv32i_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [9:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;
`ifdef RV32I_ARB_PERF_EN
  logic [31:0] perf_if_stall, perf_d_gnt;
`endif
  logic [31:0] mem [1024];
  logic [31:0] rd1, rd2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef RV32I_ARB_PERF_EN
    , .perf_if_stall(perf_if_stall), .perf_d_gnt(perf_d_gnt)
`endif
  );

  // memory model: write in grant cycle, read data appears two cycles after the read grant
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd1 <= (mem_en && !mem_we) ? mem[mem_addr] : 32'h0;
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 0; d_req = 0; d_we = 0; if_flush = 0;
  endtask

  task automatic drain();
    idle(); step(); step(); step();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; if_req = 1; d_req = 1; if_addr = 10'h3; d_addr = 10'h5;
    #1;
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL rst_if_gnt got=%0h exp=0", if_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt got=%0h exp=0", d_gnt); end
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%0h exp=0", mem_en); end
    total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {if_rvalid, d_rvalid}); end
    total++; if ({if_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {if_rdata, d_rdata}); end
`ifdef RV32I_ARB_PERF_EN
    total++; if ({perf_if_stall, perf_d_gnt} !== 64'h0) begin bad++; $display("FAIL rst_perf got=%h exp=0", {perf_if_stall, perf_d_gnt}); end
`endif
    step();
    rst_n = 1;
    #1;
    total++; if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL rel_first_gnt got=%b exp=01", {if_gnt, d_gnt}); end
    step();
    drain();
  endtask

  task automatic test_idle();
    idle(); if_addr = 10'h3ff; d_addr = 10'h155; d_wdata = 32'h12345678;
    #1;
    total++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin bad++; $display("FAIL idle_ctrl got=%b exp=0000", {if_gnt, d_gnt, mem_en, mem_we}); end
    total++; if (mem_addr !== 10'h0) begin bad++; $display("FAIL idle_addr got=%0h exp=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL idle_wdata got=%h exp=0", mem_wdata); end
    step();
  endtask

  task automatic test_contention();
    idle(); step();
    if_req = 1; d_req = 1; d_we = 0; if_addr = 10'h004; d_addr = 10'h008;
    for (int c = 1; c <= 6; c++) begin
      #1;
      total++; if ({if_gnt, d_gnt} !== ((c == 5) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL contention_c%0d got=%b exp=%b", c, {if_gnt, d_gnt}, (c == 5) ? 2'b10 : 2'b01); end
      total++; if (mem_addr !== ((c == 5) ? 10'h004 : 10'h008)) begin bad++; $display("FAIL contention_addr_c%0d got=%0h exp=%0h", c, mem_addr, (c == 5) ? 10'h004 : 10'h008); end
      step();
    end
    drain();
  endtask

  task automatic test_starve_clear();
    if_req = 1; d_req = 1; d_we = 0; if_addr = 10'h004; d_addr = 10'h008;
    step(); step(); step();
    if_req = 0;
    #1;
    total++; if ({if_gnt, d_gnt} !== 2'b01) begin bad++; $display("FAIL starve_drop got=%b exp=01", {if_gnt, d_gnt}); end
    step();
    if_req = 1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++; if ({if_gnt, d_gnt} !== ((c == 5) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL starve_clear_c%0d got=%b exp=%b", c, {if_gnt, d_gnt}, (c == 5) ? 2'b10 : 2'b01); end
      step();
    end
    drain();
  endtask

  task automatic test_read_latency();
    d_req = 1; d_we = 1; d_addr = 10'h0; d_wdata = 32'h00308133;
    #1;
    total++; if ({d_gnt, mem_we} !== 2'b11) begin bad++; $display("FAIL preload_store got=%b exp=11", {d_gnt, mem_we}); end
    step();
    d_req = 0; d_we = 0; if_req = 1; if_addr = 10'h0;
    #1;
    total++; if ({if_gnt, mem_en, mem_we} !== 3'b110) begin bad++; $display("FAIL fetch_gnt got=%b exp=110", {if_gnt, mem_en, mem_we}); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL fetch_wdata got=%h exp=0", mem_wdata); end
    step();
    idle();
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL lat_t1 got=%b exp=00", {if_rvalid, d_rvalid}); end
    step();
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b10) begin bad++; $display("FAIL lat_t2 got=%b exp=10", {if_rvalid, d_rvalid}); end
    total++; if (if_rdata !== 32'h00308133) begin bad++; $display("FAIL lat_rdata got=%h exp=00308133", if_rdata); end
    step();
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL lat_t3 got=%0h exp=0", if_rvalid); end
    total++; if (if_rdata !== 32'h00308133) begin bad++; $display("FAIL lat_hold got=%h exp=00308133", if_rdata); end
    drain();
  endtask

  task automatic test_store_load();
    d_req = 1; d_we = 1; d_addr = 10'h8; d_wdata = 32'hDEADBEEF;
    #1;
    total++; if ({d_gnt, mem_we, mem_addr} !== {2'b11, 10'h8}) begin bad++; $display("FAIL store_gnt got=%b/%0h exp=11/8", {d_gnt, mem_we}, mem_addr); end
    total++; if (mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_wdata got=%h exp=deadbeef", mem_wdata); end
    step();
    d_we = 0;
    #1;
    total++; if ({d_gnt, mem_we} !== 2'b10) begin bad++; $display("FAIL load_gnt got=%b exp=10", {d_gnt, mem_we}); end
    step();
    idle();
    #1;
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL store_no_rvalid got=%0h exp=0", d_rvalid); end
    step();
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b01) begin bad++; $display("FAIL load_rvalid got=%b exp=01", {if_rvalid, d_rvalid}); end
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h exp=deadbeef", d_rdata); end
    drain();
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 10'h0;
    #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_fetch_gnt got=%0h exp=1", if_gnt); end
    step();
    if_req = 0; if_flush = 1; d_req = 1; d_we = 0; d_addr = 10'h8;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL flush_load_gnt got=%0h exp=1", d_gnt); end
    step();
    idle();
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_inflight got=%0h exp=0", if_rvalid); end
    step();
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b01) begin bad++; $display("FAIL flush_load_ret got=%b exp=01", {if_rvalid, d_rvalid}); end
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL flush_load_data got=%h exp=deadbeef", d_rdata); end
    step();
    if_req = 1; if_flush = 1;
    #1;
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL flush_same_gnt got=%0h exp=1", if_gnt); end
    step();
    idle(); step();
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_same_cycle got=%0h exp=0", if_rvalid); end
    step();
    if_req = 1;
    step();
    idle(); step();
    if_flush = 1;
    #1;
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_at_head got=%0h exp=0", if_rvalid); end
    drain();
  endtask

  task automatic test_midop_reset();
    d_req = 1; d_we = 0; d_addr = 10'h8;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt got=%0h exp=1", d_gnt); end
    step();
    idle(); rst_n = 0;
    #1;
    total++; if ({d_rvalid, d_rdata} !== 33'h0) begin bad++; $display("FAIL midrst_during got=%0h/%h exp=0/0", d_rvalid, d_rdata); end
`ifdef RV32I_ARB_PERF_EN
    total++; if ({perf_if_stall, perf_d_gnt} !== 64'h0) begin bad++; $display("FAIL midrst_perf got=%h exp=0", {perf_if_stall, perf_d_gnt}); end
`endif
    step();
    rst_n = 1;
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL midrst_t2 got=%b exp=00", {if_rvalid, d_rvalid}); end
    step();
    #1;
    total++; if ({if_rvalid, d_rvalid} !== 2'b00) begin bad++; $display("FAIL midrst_t3 got=%b exp=00", {if_rvalid, d_rvalid}); end
`ifdef RV32I_ARB_PERF_EN
    d_req = 1; if_req = 1;
    step();
    idle();
    #1;
    total++; if ({perf_if_stall, perf_d_gnt} !== {32'd1, 32'd1}) begin bad++; $display("FAIL perf_count got=%0d/%0d exp=1/1", perf_if_stall, perf_d_gnt); end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_contention();
    test_starve_clear();
    test_read_latency();
    test_store_load();
    test_flush();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
